// File: rtl/iter_mdu.sv
// Iterative multiply/divide unit: shift-add multiply and restoring divide, one bit per cycle.
// Define MDU_MADD_EN to enable madd/maddu/msub/msubu (accumulate into {hi,lo}).
module iter_mdu #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             dz
);

  localparam int unsigned CntW = $clog2(WIDTH);

  localparam logic [3:0] OpMult  = 4'b0000;
  localparam logic [3:0] OpMultu = 4'b0001;
  localparam logic [3:0] OpDiv   = 4'b0010;
  localparam logic [3:0] OpDivu  = 4'b0011;
  localparam logic [3:0] OpMthi  = 4'b0100;
  localparam logic [3:0] OpMtlo  = 4'b0101;
  localparam logic [3:0] OpMadd  = 4'b0110;
  localparam logic [3:0] OpMaddu = 4'b0111;
  localparam logic [3:0] OpMsub  = 4'b1000;
  localparam logic [3:0] OpMsubu = 4'b1001;

  typedef enum logic [1:0] {StIdle, StMul, StDiv} state_e;

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [3:0]         op_q, op_d;
  // Multiply: {partial product, multiplier}; divide: {remainder, quotient}.
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic               neg_q, neg_d;
  logic               rneg_q, rneg_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               dz_q, dz_d;

  logic               legal, accept, last;
  logic               is_mul, is_div, is_signed;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next, prod, hilo_new;
  logic [WIDTH:0]     div_shift, div_diff;
  logic [2*WIDTH-1:0] div_next;
  logic [WIDTH-1:0]   quot, rem;

  always_comb begin
`ifdef MDU_MADD_EN
    legal = (op <= OpMsubu);
`else
    legal = (op <= OpMtlo);
`endif
    is_mul    = op inside {OpMult, OpMultu, OpMadd, OpMaddu, OpMsub, OpMsubu};
    is_div    = op inside {OpDiv, OpDivu};
    is_signed = op inside {OpMult, OpDiv, OpMadd, OpMsub};
    a_mag     = (is_signed && a[WIDTH-1]) ? -a : a;
    b_mag     = (is_signed && b[WIDTH-1]) ? -b : b;
  end

  assign accept = start && !flush && (state_q == StIdle) && legal;
  assign last   = (cnt_q == CntW'(WIDTH - 1));

  // Datapath works on magnitudes; signs are restored on the final step.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};
    prod     = neg_q ? -mul_next : mul_next;
    if (op_q inside {OpMsub, OpMsubu}) begin
      hilo_new = {hi_q, lo_q} - prod;
    end else if (op_q inside {OpMadd, OpMaddu}) begin
      hilo_new = {hi_q, lo_q} + prod;
    end else begin
      hilo_new = prod;
    end

    div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opb_q};
    div_next  = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    quot      = neg_q  ? -div_next[WIDTH-1:0] : div_next[WIDTH-1:0];
    rem       = rneg_q ? -div_next[2*WIDTH-1:WIDTH] : div_next[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    acc_d   = acc_q;
    opb_d   = opb_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dz_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          op_d   = op;
          cnt_d  = '0;
          acc_d  = {{WIDTH{1'b0}}, a_mag};
          opb_d  = b_mag;
          neg_d  = is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
          rneg_d = is_signed && a[WIDTH-1];
          if (is_mul) begin
            state_d = StMul;
          end else if (is_div) begin
            state_d = StDiv;
          end else if (op == OpMthi) begin
            hi_d = a;
          end else begin
            lo_d = a;
          end
        end
      end
      StMul: begin
        if (flush) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          acc_d = mul_next;
          cnt_d = cnt_q + CntW'(1);
          if (last) begin
            {hi_d, lo_d} = hilo_new;
            state_d      = StIdle;
            cnt_d        = '0;
          end
        end
      end
      StDiv: begin
        if (flush) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          acc_d = div_next;
          cnt_d = cnt_q + CntW'(1);
          if (last) begin
            // Divide by zero still runs full length but only raises dz.
            if (opb_q == '0) begin
              dz_d = 1'b1;
            end else begin
              hi_d = rem;
              lo_d = quot;
            end
            state_d = StIdle;
            cnt_d   = '0;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      op_q    <= '0;
      acc_q   <= '0;
      opb_q   <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
      opb_q   <= opb_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dz_q    <= dz_d;
    end
  end

  assign busy = (state_q != StIdle);
  assign hi   = hi_q;
  assign lo   = lo_q;
  assign dz   = dz_q;

endmodule

// File: tb/tb_iter_mdu.sv
// Self-checking bench for iter_mdu: expected HI/LO/dz per request kept in a scoreboard queue.
module tb_iter_mdu;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         reset, start, flush;
  logic [3:0]   op;
  logic [W-1:0] a, b;
  logic         busy, dz;
  logic [W-1:0] hi, lo;

  iter_mdu #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .flush (flush),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo),
    .dz    (dz)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
  } exp_t;

  exp_t         sb[$];
  logic [W-1:0] hm = '0;
  logic [W-1:0] lm = '0;
  int           n_vec = 0;
  int           n_err = 0;

  task automatic check(input string tag, input logic [2*W-1:0] got, input logic [2*W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", tag, got, exp);
    end
  endtask

  function automatic bit long_op(input logic [3:0] o);
`ifdef MDU_MADD_EN
    return (o <= 4'd3) || (o >= 4'd6 && o <= 4'd9);
`else
    return o <= 4'd3;
`endif
  endfunction

  // Reference model of the architectural HI/LO effect of one accepted request.
  task automatic model(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    logic signed [2*W-1:0] sx, sy;
    logic [2*W-1:0]        ux, uy;
    logic [W-1:0]          most_neg;
    logic                  d;
    sx = {{W{x[W-1]}}, x};
    sy = {{W{y[W-1]}}, y};
    ux = {{W{1'b0}}, x};
    uy = {{W{1'b0}}, y};
    most_neg = {1'b1, {(W-1){1'b0}}};
    d = 1'b0;
    case (o)
      4'd0: {hm, lm} = sx * sy;
      4'd1: {hm, lm} = ux * uy;
      4'd2: begin
        if (y == '0) d = 1'b1;
        else if (x == most_neg && y == '1) begin
          lm = most_neg;
          hm = '0;
        end else begin
          lm = $signed(x) / $signed(y);
          hm = $signed(x) % $signed(y);
        end
      end
      4'd3: begin
        if (y == '0) d = 1'b1;
        else begin
          lm = x / y;
          hm = x % y;
        end
      end
      4'd4: hm = x;
      4'd5: lm = x;
`ifdef MDU_MADD_EN
      4'd6: {hm, lm} = {hm, lm} + sx * sy;
      4'd7: {hm, lm} = {hm, lm} + ux * uy;
      4'd8: {hm, lm} = {hm, lm} - sx * sy;
      4'd9: {hm, lm} = {hm, lm} - ux * uy;
`endif
      default: ;
    endcase
    sb.push_back('{hi: hm, lo: lm, dz: d});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request for one edge, then scramble operands to prove they were latched.
  task automatic issue(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    op    = o;
    a     = x;
    b     = y;
    start = 1'b1;
    tick();
    start = 1'b0;
    op    = 4'($urandom);
    a     = $urandom;
    b     = $urandom;
  endtask

  task automatic check_sb(input string tag);
    exp_t e;
    check({tag, "_sb"}, 64'(sb.size()), 64'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({tag, "_hi"}, 64'(hi), 64'(e.hi));
      check({tag, "_lo"}, 64'(lo), 64'(e.lo));
      check({tag, "_dz"}, 64'(dz), 64'(e.dz));
    end
  endtask

  task automatic do_op(input string tag, input logic [3:0] o, input logic [W-1:0] x,
                       input logic [W-1:0] y);
    logic [2*W-1:0] old;
    int             n;
    old = {hm, lm};
    model(o, x, y);
    issue(o, x, y);
    if (long_op(o)) begin
      n = 0;
      while (busy === 1'b1 && n < W + 4) begin
        check({tag, "_hold"}, {hi, lo}, old);
        tick();
        n++;
      end
      check({tag, "_lat"}, 64'(n), 64'(W));
    end else begin
      check({tag, "_busy"}, 64'(busy), 64'd0);
    end
    check_sb(tag);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, want finish");
    $fatal(1);
  end

  initial begin
    logic [2*W-1:0] old;
    reset = 1'b1;
    start = 1'b0;
    flush = 1'b0;
    op    = '0;
    a     = '0;
    b     = '0;
    #2 reset = 1'b0;
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_hilo", {hi, lo}, '0);
    check("rst_dz", 64'(dz), 64'd0);
    #9 reset = 1'b1;
    tick();

    do_op("mthi", 4'd4, 32'h0000_1111, 32'h0);
    do_op("mtlo", 4'd5, 32'h0000_2222, 32'h0);
    do_op("mult_neg", 4'd0, 32'hFFFF_FFFF, 32'h0000_0002);
    do_op("multu", 4'd1, 32'hFFFF_FFFF, 32'h0000_0002);
    do_op("div_m7", 4'd2, 32'hFFFF_FFF9, 32'h0000_0002);
    do_op("div_ovf", 4'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    do_op("divu", 4'd3, 32'd1000, 32'd7);
    do_op("div_nn", 4'd2, 32'hFFFF_FF9C, 32'hFFFF_FFF9);

    // Divide by zero leaves HI/LO alone and pulses dz for one cycle.
    do_op("pre_hi", 4'd4, 32'h11, 32'h0);
    do_op("pre_lo", 4'd5, 32'h22, 32'h0);
    do_op("divu_z", 4'd3, 32'd5, 32'd0);
    tick();
    check("dz_pulse", 64'(dz), 64'd0);

    do_op("ill_a", 4'b1010, 32'h1, 32'h1);
    do_op("ill_f", 4'b1111, 32'h1, 32'h1);

    do_op("acc_hi", 4'd4, 32'h0, 32'h0);
    do_op("acc_lo", 4'd5, 32'hFFFF_FFFF, 32'h0);
    do_op("maddu", 4'd7, 32'h1, 32'h1);
    do_op("msub", 4'd8, 32'hFFFF_FFFD, 32'h0000_0005);
    do_op("madd", 4'd6, 32'h8000_0000, 32'h0000_0003);
    do_op("msubu", 4'd9, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

    for (int i = 0; i < 8; i++) begin
      do_op("rand", 4'($urandom_range(0, 3)), $urandom, (i == 3) ? 32'h0 : $urandom);
    end

    // Flush mid-multiply; a start while busy is ignored.
    old = {hm, lm};
    issue(4'd0, 32'h0001_2345, 32'h0006_789A);
    for (int c = 1; c < 10; c++) begin
      if (c == 5) begin
        start = 1'b1;
        op    = 4'd4;
        a     = 32'hDEAD_BEEF;
      end
      tick();
      start = 1'b0;
    end
    check("fl_busy_pre", 64'(busy), 64'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fl_busy", 64'(busy), 64'd0);
    check("fl_hilo", {hi, lo}, old);
    check("fl_dz", 64'(dz), 64'd0);

    // Start together with flush is rejected.
    start = 1'b1;
    flush = 1'b1;
    op    = 4'd5;
    a     = 32'hAAAA_5555;
    tick();
    op    = 4'd0;
    tick();
    start = 1'b0;
    flush = 1'b0;
    check("sf_busy", 64'(busy), 64'd0);
    check("sf_hilo", {hi, lo}, old);
    do_op("post_fl", 4'd1, 32'd12345, 32'd678);

    // Asynchronous reset between edges mid-divide.
    issue(4'd2, 32'd100000, 32'd7);
    repeat (16) tick();
    #2 reset = 1'b0;
    #1;
    check("ar_busy", 64'(busy), 64'd0);
    check("ar_hilo", {hi, lo}, '0);
    check("ar_dz", 64'(dz), 64'd0);
    hm = '0;
    lm = '0;
    @(posedge clk);
    #2 reset = 1'b1;
    do_op("b2b_multu", 4'd1, 32'hFFFF_0000, 32'h0001_0001);
    do_op("b2b_mtlo", 4'd5, 32'h0BAD_F00D, 32'h0);
    do_op("b2b_div", 4'd2, 32'h7FFF_FFFF, 32'hFFFF_FFFE);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
